// File: rtl/alu_step_sequencer_if.sv
// rtl/alu_step_sequencer_if.sv - step/abort/flag inputs and enable/status outputs of the ALU step sequencer
interface alu_step_sequencer_if #(
    parameter int CNT_W = 8,
    parameter int OP_W  = 2
);
    logic             STEP;
    logic             ABORT;
    logic [OP_W-1:0]  OPsel;
    logic [3:0]       FLAGS;
    logic             enA;
    logic             enALU;
    logic             enC;
    logic             selA;
    logic [OP_W-1:0]  OPout;
    logic [1:0]       state;
    logic             done;
    logic [CNT_W-1:0] opCount;
    logic             ovfSticky;

    modport master (
        output STEP, ABORT, OPsel, FLAGS,
        input  enA, enALU, enC, selA, OPout, state, done, opCount, ovfSticky
    );

    modport slave (
        input  STEP, ABORT, OPsel, FLAGS,
        output enA, enALU, enC, selA, OPout, state, done, opCount, ovfSticky
    );
endinterface

// File: rtl/alu_step_sequencer.sv
// rtl/alu_step_sequencer.sv - step-press FSM producing one-cycle register enables; ACCUM_CHAIN_EN enables A<=C chaining
module alu_step_sequencer #(
    parameter int CNT_W = 8,
    parameter int OP_W  = 2
) (
    input  logic                 CLK50M,
    input  logic                 RST,
    alu_step_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        LOAD_A    = 2'b00,
        LOAD_B    = 2'b01,
        SHOW      = 2'b10,
        UNUSED_ST = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   step_q;
    logic   step_pulse;
    logic   en_a_d;
    logic   en_alu_d;
    logic   en_c_d;
    logic   sel_a_d;
    logic   unused_flags;

    // Only V participates in the sticky flag; the other ALU flags pass by.
    assign unused_flags = ^bus.FLAGS[2:0];

    // Rising edge of the debounced key; step_q starts high so a key held through reset is not a press.
    assign step_pulse = bus.STEP & ~step_q;

    assign bus.OPout = bus.OPsel;
    assign bus.state = state_q;

    // Next state and next-cycle enables; abort overrides any pending press.
    always_comb begin
        state_d  = state_q;
        en_a_d   = 1'b0;
        en_alu_d = 1'b0;
        en_c_d   = 1'b0;
        sel_a_d  = 1'b0;
        if (bus.ABORT) begin
            state_d = LOAD_A;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (step_pulse) begin
                        state_d  = LOAD_B;
                        en_a_d   = 1'b1;
                        en_alu_d = 1'b1;
                    end
                end
                LOAD_B: begin
                    if (step_pulse) begin
                        state_d = SHOW;
                        en_c_d  = 1'b1;
                    end
                end
                SHOW: begin
                    if (step_pulse) begin
`ifdef ACCUM_CHAIN_EN
                        state_d = LOAD_B;
                        en_a_d  = 1'b1;
                        sel_a_d = 1'b1;
`else
                        state_d = LOAD_A;
`endif
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    // State, key history and registered enables.
    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            state_q   <= LOAD_A;
            step_q    <= 1'b1;
            bus.enA   <= 1'b0;
            bus.enALU <= 1'b0;
            bus.enC   <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= bus.STEP;
            bus.enA   <= en_a_d;
            bus.enALU <= en_alu_d;
            bus.enC   <= en_c_d;
            bus.done  <= en_c_d;
        end
    end

`ifdef ACCUM_CHAIN_EN
    // A-source select follows the chaining enable so A captures C only on that cycle.
    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            bus.selA <= 1'b0;
        end else begin
            bus.selA <= sel_a_d;
        end
    end
`else
    logic unused_sel;
    assign unused_sel = sel_a_d;
    assign bus.selA   = 1'b0;
`endif

    // Completed-operation counter advances together with enC and wraps silently.
    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            bus.opCount <= '0;
        end else if (en_c_d) begin
            bus.opCount <= bus.opCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky overflow samples V only while enC is high; abort clears it.
    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            bus.ovfSticky <= 1'b0;
        end else if (bus.ABORT) begin
            bus.ovfSticky <= 1'b0;
        end else if (bus.enC) begin
            bus.ovfSticky <= bus.ovfSticky | bus.FLAGS[3];
        end
    end
endmodule
